// File: rtl/l1_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter (m0 = I-cache refill, m1 = D-cache refill/writeback).
// The ack watchdog and ABORT handling exist only when WB_ARB_TIMEOUT_EN is defined.
module l1_wb_arbiter #(
    parameter int ADDR_LEN       = 32,
    parameter int DATA_LEN       = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_we_i,
    input  logic [ADDR_LEN-1:0] m0_adr_i,
    input  logic [DATA_LEN-1:0] m0_dat_i,
    input  logic [9:0]          m0_bl_i,
    output logic                m0_ack_o,
    output logic [DATA_LEN-1:0] m0_dat_o,
    output logic                m0_err_o,
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_we_i,
    input  logic [ADDR_LEN-1:0] m1_adr_i,
    input  logic [DATA_LEN-1:0] m1_dat_i,
    input  logic [9:0]          m1_bl_i,
    output logic                m1_ack_o,
    output logic [DATA_LEN-1:0] m1_dat_o,
    output logic                m1_err_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [ADDR_LEN-1:0] s_adr_o,
    output logic [DATA_LEN-1:0] s_dat_o,
    output logic [9:0]          s_bl_o,
    input  logic                s_ack_i,
    input  logic [DATA_LEN-1:0] s_dat_i
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

    state_t state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   cur_cyc;
    logic   timeout;

    // last_grant always names the owner while in GNTx or ABORT.
    assign cur_cyc = last_grant_q ? m1_cyc_i : m0_cyc_i;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Cleared by ack and by every non-granted cycle, so a new grant starts from zero.
    always_comb begin
        tmo_cnt_d = '0;
        timeout   = 1'b0;
        if ((state_q == GNT0 || state_q == GNT1) && cur_cyc && !s_ack_i) begin
            if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))
                timeout = 1'b1;
            else
                tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) tmo_cnt_q <= '0;
        else       tmo_cnt_q <= tmo_cnt_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last_grant_q)) begin
                    state_d      = GNT0;
                    last_grant_d = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d      = GNT1;
                    last_grant_d = 1'b1;
                end
            end
            GNT0, GNT1: begin
                if (!cur_cyc)     state_d = IDLE;
                else if (timeout) state_d = ABORT;
            end
            ABORT: begin
                if (!cur_cyc) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Slave side follows the owner combinationally, so it drops in the same cycle as cyc.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_bl_o   = '0;
        m0_ack_o = 1'b0;
        m0_dat_o = '0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_dat_o = '0;
        m1_err_o = 1'b0;
        case (state_q)
            GNT0: begin
                s_cyc_o  = m0_cyc_i & ~timeout;
                s_stb_o  = m0_stb_i & ~timeout;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_bl_o   = m0_bl_i;
                m0_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
                m0_err_o = timeout;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i & ~timeout;
                s_stb_o  = m1_stb_i & ~timeout;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_bl_o   = m1_bl_i;
                m1_ack_o = s_ack_i;
                m1_dat_o = s_dat_i;
                m1_err_o = timeout;
            end
            default: ;
        endcase
    end

endmodule
